// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register with flush/bubble/hold and a one-entry skid buffer.
// Also keeps a saturating count of cycles in which the upstream stage was stalled.
module pipe_stage_reg #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LANES   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 1,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*ADDR_W-1:0]   in_pc,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*ADDR_W-1:0]   out_pc,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      skid_full,
    output logic [CNT_W-1:0]          stall_cnt
);

    // Flow control: stall[STAGE] = 1 means the upstream producer is stopped this cycle;
    // stall[STAGE+1] = 1 means the downstream consumer is stopped and must see stable
    // outputs (hold). Upstream stopped with downstream free inserts a NOP bubble.
    // A lane group is accepted on any edge where in_valid has a bit set and either the
    // stage advances or the skid is empty; otherwise it is dropped.
    logic s_up;
    logic s_dn;
    logic any_in;
    logic unused_stall;

    assign s_up         = stall[STAGE];
    assign s_dn         = stall[STAGE+1];
    assign any_in       = |in_valid;
    assign unused_stall = ^stall;

    // Invalid lanes carry all-zero pc/data so downstream always sees a clean NOP.
    logic [LANES*ADDR_W-1:0] in_pc_m;
    logic [LANES*DATA_W-1:0] in_data_m;

    always_comb begin
        in_pc_m   = '0;
        in_data_m = '0;
        for (int k = 0; k < LANES; k++) begin
            if (in_valid[k]) begin
                in_pc_m[k*ADDR_W +: ADDR_W]   = in_pc[k*ADDR_W +: ADDR_W];
                in_data_m[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    logic [LANES-1:0]        skid_valid;
    logic [LANES*ADDR_W-1:0] skid_pc;
    logic [LANES*DATA_W-1:0] skid_data;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic                    full_q;
            logic [LANES-1:0]        valid_q;
            logic [LANES*ADDR_W-1:0] pc_q;
            logic [LANES*DATA_W-1:0] data_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    full_q  <= 1'b0;
                    valid_q <= '0;
                    pc_q    <= '0;
                    data_q  <= '0;
                end else if (flush) begin
                    full_q  <= 1'b0;
                    valid_q <= '0;
                    pc_q    <= '0;
                    data_q  <= '0;
                end else if (s_up) begin
                    if (!full_q && any_in) begin
                        full_q  <= 1'b1;
                        valid_q <= in_valid;
                        pc_q    <= in_pc_m;
                        data_q  <= in_data_m;
                    end
                end else if (full_q) begin
                    // Skid drains to the outputs; refill from the input keeps order.
                    full_q  <= any_in;
                    valid_q <= any_in ? in_valid  : '0;
                    pc_q    <= any_in ? in_pc_m   : '0;
                    data_q  <= any_in ? in_data_m : '0;
                end
            end

            assign skid_full  = full_q;
            assign skid_valid = valid_q;
            assign skid_pc    = pc_q;
            assign skid_data  = data_q;
        end else begin : g_no_skid
            assign skid_full  = 1'b0;
            assign skid_valid = '0;
            assign skid_pc    = '0;
            assign skid_data  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            out_pc    <= '0;
            out_data  <= '0;
            stall_cnt <= '0;
        end else begin
            if (s_up && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                out_valid <= '0;
                out_pc    <= '0;
                out_data  <= '0;
            end else if (s_up) begin
                if (!s_dn) begin
                    out_valid <= '0;
                    out_pc    <= '0;
                    out_data  <= '0;
                end
            end else if (skid_full) begin
                out_valid <= skid_valid;
                out_pc    <= skid_pc;
                out_data  <= skid_data;
            end else begin
                out_valid <= in_valid;
                out_pc    <= in_pc_m;
                out_data  <= in_data_m;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps followed by random traffic,
// compared against a queue-based model of the stage register and its skid buffer.
module tb_pipe_stage_reg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LANES   = 2;
    localparam int STALL_W = 6;
    localparam int STAGE   = 1;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [LANES-1:0]        valid;
        logic [LANES*ADDR_W-1:0] pc;
        logic [LANES*DATA_W-1:0] data;
    } grp_t;

    logic                    clk;
    logic                    rst;
    logic [STALL_W-1:0]      stall;
    logic                    flush;
    logic [LANES-1:0]        in_valid;
    logic [LANES*ADDR_W-1:0] in_pc;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        out_valid;
    logic [LANES*ADDR_W-1:0] out_pc;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    skid_full;
    logic [CNT_W-1:0]        stall_cnt;

    int   total;
    int   bad;
    grp_t m_out;
    grp_t skid_q[$];
    int   m_cnt;

    pipe_stage_reg #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .STALL_W(STALL_W),
        .STAGE(STAGE), .SKID_EN(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
        .skid_full(skid_full), .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic grp_t mk(logic [LANES-1:0] v, logic [LANES*ADDR_W-1:0] pc,
                                logic [LANES*DATA_W-1:0] d);
        grp_t g;
        g.valid = v;
        g.pc    = '0;
        g.data  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (v[k]) begin
                g.pc[k*ADDR_W +: ADDR_W]   = pc[k*ADDR_W +: ADDR_W];
                g.data[k*DATA_W +: DATA_W] = d[k*DATA_W +: DATA_W];
            end
        end
        return g;
    endfunction

    // reference model: one edge of the stage, skid as a queue of at most one group
    task automatic model_edge(logic [STALL_W-1:0] st, logic fl, grp_t g);
        bit up = st[STAGE];
        bit dn = st[STAGE+1];
        if (up) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (fl) begin
            m_out = '0;
            skid_q.delete();
        end else if (up) begin
            if (!dn) m_out = '0;
            if (skid_q.size() == 0 && g.valid != '0) skid_q.push_back(g);
        end else if (skid_q.size() != 0) begin
            m_out = skid_q.pop_front();
            if (g.valid != '0) skid_q.push_back(g);
        end else begin
            m_out = g;
        end
    endtask

    task automatic model_reset();
        m_out = '0;
        skid_q.delete();
        m_cnt = 0;
    endtask

    // scoreboard compare
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(m_out.valid));
        check({tag, ".pc"},    64'(out_pc),    64'(m_out.pc));
        check({tag, ".data"},  64'(out_data),  64'(m_out.data));
        check({tag, ".skid"},  64'(skid_full), 64'(skid_q.size() != 0));
        check({tag, ".cnt"},   64'(stall_cnt), 64'(m_cnt));
    endtask

    // driver: present inputs, take one edge, update model, check after the edge
    task automatic step(string tag, logic [STALL_W-1:0] st, logic fl, logic [LANES-1:0] v,
                        logic [LANES*ADDR_W-1:0] pc, logic [LANES*DATA_W-1:0] d);
        stall    = st;
        flush    = fl;
        in_valid = v;
        in_pc    = pc;
        in_data  = d;
        @(posedge clk);
        model_edge(st, fl, mk(v, pc, d));
        #1;
        check_all(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst      = 1'b0;
        stall    = '0;
        flush    = 1'b0;
        in_valid = 2'b11;
        in_pc    = {32'h104, 32'h100};
        in_data  = {32'hD1, 32'hD0};
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst = 1'b1;

        step("first_load", 6'b000000, 1'b0, 2'b11, {32'h104, 32'h100}, {32'hD1, 32'hD0});
        check("first_load.pc_const", 64'(out_pc), {32'h104, 32'h100});

        step("bubble", 6'b000010, 1'b0, 2'b11, {32'h10C, 32'h108}, {32'hD3, 32'hD2});
        check("bubble.skid_const", 64'(skid_full), 64'd1);
        step("drain1", 6'b000000, 1'b0, 2'b11, {32'h114, 32'h110}, {32'hD5, 32'hD4});
        check("drain1.pc_const", 64'(out_pc), {32'h10C, 32'h108});
        step("drain2", 6'b000000, 1'b0, 2'b00, '0, '0);
        check("drain2.pc_const", 64'(out_pc), {32'h114, 32'h110});

        step("hold_pre", 6'b000000, 1'b0, 2'b11, {32'h204, 32'h200}, {32'hE1, 32'hE0});
        step("hold1", 6'b000110, 1'b0, 2'b11, {32'h20C, 32'h208}, {32'hE3, 32'hE2});
        step("hold2", 6'b000110, 1'b0, 2'b11, {32'h214, 32'h210}, {32'hE5, 32'hE4});
        step("hold3", 6'b000110, 1'b0, 2'b11, {32'h21C, 32'h218}, {32'hE7, 32'hE6});
        check("hold3.pc_const", 64'(out_pc), {32'h204, 32'h200});

        step("flush", 6'b000110, 1'b1, 2'b11, {32'h224, 32'h220}, {32'hE9, 32'hE8});
        step("partial", 6'b000000, 1'b0, 2'b01, {32'hDEAD, 32'h300}, {32'hBEEF, 32'h30});
        check("partial.pc_const", 64'(out_pc), {32'h0, 32'h300});

        for (int i = 0; i < 20; i++) step("sat", 6'b000010, 1'b0, 2'b00, '0, '0);
        check("sat.cnt_const", 64'(stall_cnt), 64'd15);

        // asynchronous reset while stalled with the skid full
        step("pre_rst", 6'b000000, 1'b0, 2'b10, {32'h404, 32'h400}, {32'hF1, 32'hF0});
        step("pre_rst_fill", 6'b000110, 1'b0, 2'b11, {32'h40C, 32'h408}, {32'hF3, 32'hF2});
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 6'b000000, 1'b0, 2'b11, {32'h504, 32'h500}, {32'hA1, 32'hA0});

        for (int i = 0; i < 300; i++) begin
            logic [STALL_W-1:0] st;
            st = STALL_W'($urandom);
            if ($urandom_range(0, 2) == 0) st[STAGE] = 1'b0;
            step("rand", st, $urandom_range(0, 15) == 0, 2'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
